indirect_prefetch_engine: RTL and testbench
===========================================

INDIRECT_PREFETCH_ENGINE -- requirements
Module: indirect_prefetch_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address and data width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning element-count width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), meaning index buffer entries.
REQ-004 SHALL have parameter IDX_STRIDE, default 4, meaning byte step between consecutive index words.
REQ-005 Ports (name direction width meaning), one clock; reset is asynchronous and active-high:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high
  trigger  in  1  one-cycle start pulse
  abort  in  1  one-cycle cancel pulse
  idx_base_i  in  ADDR_W  index array base
  tgt_base_i  in  ADDR_W  target array base
  count_i  in  CNT_W  number of elements
  elem_shift_i  in  3  log2 target element size
  cache_data_req_o  out  1  index-load request pulse
  cache_r_addr_o  out  ADDR_W  index-load address
  wait_cache  in  1  cache busy with a load
  cache_data_ready  in  1  cache_data_i valid
  cache_data_i  in  ADDR_W  returned index value
  pf_req_o  out  1  prefetch valid
  pf_addr_o  out  ADDR_W  prefetch address
  pf_ack_i  in  1  prefetch accepted
  busy_o  out  1  engine active
  done_o  out  1  one-cycle completion pulse
  pf_issued_cnt_o  out  CNT_W  prefetches accepted since trigger

Function
REQ-006 SHALL capture idx_base_i, tgt_base_i, count_i, elem_shift_i on trigger in IDLE; trigger while busy_o=1 SHALL be ignored.
REQ-007 Fetch FSM states SHALL be IDLE, REQ, WAIT, DRAIN.
REQ-008 IDLE->REQ on trigger with count_i!=0; count_i==0 SHALL produce done_o the next cycle and remain IDLE.
REQ-009 REQ: when FIFO not full and wait_cache=0, SHALL assert cache_data_req_o for exactly one cycle with address idx_base+i*IDX_STRIDE, then go WAIT; otherwise SHALL hold in REQ without request.
REQ-010 WAIT: on cache_data_ready SHALL push cache_data_i into the FIFO, increment i, then go REQ if i<count else DRAIN; at most one index load outstanding.
REQ-011 Issue side SHALL present pf_req_o=1 whenever FIFO non-empty, pf_addr_o=tgt_base+(head<<elem_shift), and SHALL pop on pf_req_o&pf_ack_i; pf_addr_o SHALL stay stable until ack.
REQ-012 Simultaneous push and pop SHALL keep occupancy unchanged; push into a full FIFO SHALL not occur by construction (REQ-009).
REQ-013 DRAIN: when FIFO empty SHALL pulse done_o one cycle and return to IDLE.
REQ-014 All address arithmetic SHALL wrap modulo 2^ADDR_W; index values are unsigned.
REQ-015 abort SHALL return to IDLE next cycle, flush FIFO, drop pf_req_o (unacknowledged prefetch discarded), no done_o; a late cache_data_ready SHALL be ignored.
REQ-016 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-017 On reset all outputs SHALL be 0, FSM IDLE, FIFO empty, i and counters 0, irrespective of clock.
REQ-018 Reset mid-operation SHALL discard all in-flight state with no done_o.

Configuration
REQ-019 Macro PF_PERF_CNT_EN defined: pf_issued_cnt_o counts accepted prefetches, cleared on trigger, saturating at all-ones; undefined: pf_issued_cnt_o tied to 0 and no counter logic present.

Structure
REQ-020 Shared package pf_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-021 The index buffer SHALL be a separate sub-module pf_idx_fifo (synchronous FIFO, full/empty flags).

Verification
REQ-022 count=3, idx_base=0x100, indices {5,2,9}, tgt_base=0x2000, shift=2, ack every cycle -> cache addrs 0x100,0x104,0x108; pf addrs 0x2014,0x2008,0x2024; one done_o.
REQ-023 count=8, FIFO_DEPTH=4, pf_ack_i held 0 -> exactly 4 index loads then REQ stalls; releasing ack completes all 8.
REQ-024 count=0 trigger -> done_o next cycle, no cache or pf requests.
REQ-025 abort during WAIT with 2 FIFO entries -> IDLE next cycle, pf_req_o=0, no done_o, following cache_data_ready ignored.
REQ-026 tgt_base=0xFFFFFFF0, index 8, shift 2 -> pf_addr_o=0x00000010; trigger while busy ignored.
REQ-027 With PF_PERF_CNT_EN, REQ-022 run -> pf_issued_cnt_o=3; without it -> 0.

Source files
------------

// File: rtl/pf_pkg.sv
// Shared types and default configuration for the indirect prefetch engine.
package pf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } pf_state_e;

  localparam int PF_ADDR_W     = 32;
  localparam int PF_CNT_W      = 16;
  localparam int PF_FIFO_DEPTH = 4;
  localparam int PF_IDX_STRIDE = 4;

endpackage

// File: rtl/pf_idx_fifo.sv
// Synchronous index buffer between the index-load side and the prefetch issue side.
module pf_idx_fifo
  import pf_pkg::*;
#(
  parameter int W     = PF_ADDR_W,
  parameter int DEPTH = PF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + (AW+1)'(1);
      if (pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries no reset; the engine masks head while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  assign head  = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/indirect_prefetch_engine.sv
// Walks an index array, buffers loaded indices and issues target-array prefetches.
// Optional PF_PERF_CNT_EN enables the accepted-prefetch counter.
module indirect_prefetch_engine
  import pf_pkg::*;
#(
  parameter int ADDR_W     = PF_ADDR_W,
  parameter int CNT_W      = PF_CNT_W,
  parameter int FIFO_DEPTH = PF_FIFO_DEPTH,
  parameter int IDX_STRIDE = PF_IDX_STRIDE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              abort,
  input  logic [ADDR_W-1:0] idx_base_i,
  input  logic [ADDR_W-1:0] tgt_base_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [2:0]        elem_shift_i,
  output logic              cache_data_req_o,
  output logic [ADDR_W-1:0] cache_r_addr_o,
  input  logic              wait_cache,
  input  logic              cache_data_ready,
  input  logic [ADDR_W-1:0] cache_data_i,
  output logic              pf_req_o,
  output logic [ADDR_W-1:0] pf_addr_o,
  input  logic              pf_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  pf_issued_cnt_o
);

  pf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_base_q, idx_base_d;
  logic [ADDR_W-1:0] tgt_base_q, tgt_base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        shift_q, shift_d;
  logic [CNT_W-1:0]  i_q, i_d, i_nxt;
  logic              done_q, done_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] fifo_head;

  assign i_nxt = i_q + CNT_W'(1);

  always_comb begin
    state_d          = state_q;
    idx_base_d       = idx_base_q;
    tgt_base_d       = tgt_base_q;
    count_d          = count_q;
    shift_d          = shift_q;
    i_d              = i_q;
    done_d           = 1'b0;
    cache_data_req_o = 1'b0;
    fifo_push        = 1'b0;
    fifo_flush       = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          idx_base_d = idx_base_i;
          tgt_base_d = tgt_base_i;
          count_d    = count_i;
          shift_d    = elem_shift_i;
          i_d        = '0;
          if (count_i == '0) done_d  = 1'b1;
          else               state_d = REQ;
        end
      end
      REQ: begin
        // A free slot is reserved here, so the later push can never overflow.
        if (!fifo_full && !wait_cache) begin
          cache_data_req_o = 1'b1;
          state_d          = WAIT;
        end
      end
      WAIT: begin
        if (cache_data_ready) begin
          fifo_push = 1'b1;
          i_d       = i_nxt;
          state_d   = (i_nxt < count_q) ? REQ : DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d          = IDLE;
      fifo_flush       = 1'b1;
      fifo_push        = 1'b0;
      done_d           = 1'b0;
      cache_data_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_base_q <= '0;
      tgt_base_q <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      i_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_base_q <= idx_base_d;
      tgt_base_q <= tgt_base_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      i_q        <= i_d;
      done_q     <= done_d;
    end
  end

  pf_idx_fifo #(
    .W    (ADDR_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_data(cache_data_i),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign fifo_pop       = pf_req_o & pf_ack_i;
  assign pf_req_o       = !fifo_empty;
  assign pf_addr_o      = fifo_empty ? '0 : tgt_base_q + (fifo_head << shift_q);
  assign cache_r_addr_o = idx_base_q + ADDR_W'(i_q) * ADDR_W'(IDX_STRIDE);
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;

`ifdef PF_PERF_CNT_EN
  logic [CNT_W-1:0] pf_cnt_q, pf_cnt_d;
  logic             start;

  assign start = (state_q == IDLE) && trigger && !abort;

  always_comb begin
    pf_cnt_d = pf_cnt_q;
    if (start)                           pf_cnt_d = '0;
    else if (fifo_pop && pf_cnt_q != '1) pf_cnt_d = pf_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pf_cnt_q <= '0;
    else       pf_cnt_q <= pf_cnt_d;
  end

  assign pf_issued_cnt_o = pf_cnt_q;
`else
  assign pf_issued_cnt_o = '0;
`endif

endmodule

// File: tb/tb_indirect_prefetch_engine.sv
// Directed bench for indirect_prefetch_engine with a small latency-programmable cache responder.
module tb_indirect_prefetch_engine;

`ifdef PF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0, abort = 1'b0;
  logic [31:0] idx_base_i = '0, tgt_base_i = '0;
  logic [15:0] count_i = '0;
  logic [2:0]  elem_shift_i = '0;
  logic        cache_data_req_o;
  logic [31:0] cache_r_addr_o;
  logic        wait_cache = 1'b0;
  logic        cache_data_ready = 1'b0;
  logic [31:0] cache_data_i = '0;
  logic        pf_req_o;
  logic [31:0] pf_addr_o;
  logic        pf_ack_i = 1'b0;
  logic        busy_o, done_o;
  logic [15:0] pf_issued_cnt_o;

  always #5 clk = ~clk;

  indirect_prefetch_engine dut (
    .clk(clk), .reset(reset), .trigger(trigger), .abort(abort),
    .idx_base_i(idx_base_i), .tgt_base_i(tgt_base_i), .count_i(count_i),
    .elem_shift_i(elem_shift_i), .cache_data_req_o(cache_data_req_o),
    .cache_r_addr_o(cache_r_addr_o), .wait_cache(wait_cache),
    .cache_data_ready(cache_data_ready), .cache_data_i(cache_data_i),
    .pf_req_o(pf_req_o), .pf_addr_o(pf_addr_o), .pf_ack_i(pf_ack_i),
    .busy_o(busy_o), .done_o(done_o), .pf_issued_cnt_o(pf_issued_cnt_o)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Observed traffic, sampled mid-cycle.
  logic [31:0] cq[$];
  logic [31:0] pq[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (cache_data_req_o)    cq.push_back(cache_r_addr_o);
      if (pf_req_o && pf_ack_i) pq.push_back(pf_addr_o);
      if (done_o)              done_cnt++;
    end
  end

  // Cache model: answers each index load lat+2 cycles after the request.
  logic [31:0] idx_mem [16];
  logic [31:0] idx_base_cur = '0;
  int          lat = 0;
  bit          pend = 1'b0, r_fire = 1'b0;
  int          pcnt = 0;
  logic [31:0] paddr = '0, r_data = '0, off = '0;

  always @(negedge clk) begin
    r_fire = 1'b0;
    if (reset) pend = 1'b0;
    else if (cache_data_req_o) begin
      pend  = 1'b1;
      pcnt  = lat;
      paddr = cache_r_addr_o;
    end else if (pend) begin
      if (pcnt == 0) begin
        off    = (paddr - idx_base_cur) >> 2;
        r_data = idx_mem[off[3:0]];
        r_fire = 1'b1;
        pend   = 1'b0;
      end else pcnt--;
    end
  end

  always @(posedge clk) begin
    #1;
    cache_data_ready = r_fire;
    cache_data_i     = r_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger(input logic [31:0] ib, input logic [31:0] tb,
                               input logic [15:0] cnt, input logic [2:0] sh);
    tick();
    idx_base_i   = ib;
    tgt_base_i   = tb;
    count_i      = cnt;
    elem_shift_i = sh;
    trigger      = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit seen = 1'b0;
    for (int c = 0; c < max && !seen; c++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  logic [31:0] e1_c[3] = '{32'h100, 32'h104, 32'h108};
  logic [31:0] e1_p[3] = '{32'h2014, 32'h2008, 32'h2024};
  int d0, d1;
  bit hit;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_creq", 64'(cache_data_req_o), 0);
    chk("rst_caddr", 64'(cache_r_addr_o), 0);
    chk("rst_pfreq", 64'(pf_req_o), 0);
    chk("rst_pfaddr", 64'(pf_addr_o), 0);
    chk("rst_cnt", 64'(pf_issued_cnt_o), 0);
    tick();
    reset = 1'b0;

    // Basic walk, with the cache initially busy
    idx_base_cur = 32'h100;
    idx_mem[0] = 5; idx_mem[1] = 2; idx_mem[2] = 9;
    lat = 1; pf_ack_i = 1'b1; wait_cache = 1'b1;
    cq.delete(); pq.delete(); d0 = done_cnt;
    pulse_trigger(32'h100, 32'h2000, 16'd3, 3'd2);
    @(negedge clk);
    chk("t1_busy", 64'(busy_o), 1);
    chk("t1_hold_nreq", 64'(cache_data_req_o), 0);
    tick();
    wait_cache = 1'b0;
    wait_done("t1_done", 100);
    tick(); tick();
    chk("t1_ncache", 64'(cq.size()), 3);
    chk("t1_npf", 64'(pq.size()), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t1_caddr%0d", k), 64'(k < cq.size() ? cq[k] : 32'hdead), 64'(e1_c[k]));
      chk($sformatf("t1_paddr%0d", k), 64'(k < pq.size() ? pq[k] : 32'hdead), 64'(e1_p[k]));
    end
    chk("t1_ndone", 64'(done_cnt - d0), 1);
    chk("t1_idle", 64'(busy_o), 0);
    chk("t1_cnt", 64'(pf_issued_cnt_o), PERF ? 64'd3 : 64'd0);

    // Zero-length request
    cq.delete(); pq.delete();
    pulse_trigger(32'h300, 32'h5000, 16'd0, 3'd1);
    @(negedge clk);
    chk("t2_done", 64'(done_o), 1);
    chk("t2_busy", 64'(busy_o), 0);
    tick();
    @(negedge clk);
    chk("t2_done_once", 64'(done_o), 0);
    repeat (3) tick();
    chk("t2_ncache", 64'(cq.size()), 0);
    chk("t2_npf", 64'(pq.size()), 0);
    chk("t2_cnt_clr", 64'(pf_issued_cnt_o), 0);

    // Backpressure fills the buffer and stalls index loads
    idx_base_cur = 32'h1000;
    for (int k = 0; k < 8; k++) idx_mem[k] = 32'(3 * k + 1);
    lat = 0; pf_ack_i = 1'b0;
    cq.delete(); pq.delete(); d0 = done_cnt;
    pulse_trigger(32'h1000, 32'h4000, 16'd8, 3'd3);
    repeat (40) tick();
    @(negedge clk);
    chk("t3_nstall", 64'(cq.size()), 4);
    chk("t3_busy", 64'(busy_o), 1);
    chk("t3_nreq", 64'(cache_data_req_o), 0);
    chk("t3_pfreq", 64'(pf_req_o), 1);
    chk("t3_pfaddr", 64'(pf_addr_o), 64'h4008);
    tick();
    @(negedge clk);
    chk("t3_pfaddr_hold", 64'(pf_addr_o), 64'h4008);
    tick();
    pf_ack_i = 1'b1;
    wait_done("t3_done", 200);
    tick(); tick();
    chk("t3_ncache", 64'(cq.size()), 8);
    chk("t3_npf", 64'(pq.size()), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_caddr%0d", k), 64'(k < cq.size() ? cq[k] : 32'hdead), 64'(32'h1000 + 4 * k));
      chk($sformatf("t3_paddr%0d", k), 64'(k < pq.size() ? pq[k] : 32'hdead),
          64'(32'h4000 + ((3 * k + 1) << 3)));
    end
    chk("t3_ndone", 64'(done_cnt - d0), 1);
    chk("t3_cnt", 64'(pf_issued_cnt_o), PERF ? 64'd8 : 64'd0);

    // Abort while the third load is outstanding
    idx_base_cur = 32'h200;
    for (int k = 0; k < 5; k++) idx_mem[k] = 32'(k + 1);
    lat = 3; pf_ack_i = 1'b0;
    cq.delete(); pq.delete(); d0 = done_cnt;
    pulse_trigger(32'h200, 32'h6000, 16'd5, 3'd0);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (cq.size() >= 3) hit = 1'b1;
    end
    chk("t4_reach_wait", 64'(hit), 1);
    tick();
    abort = 1'b1;
    @(negedge clk);
    chk("t4_pre_pfreq", 64'(pf_req_o), 1);
    chk("t4_pre_busy", 64'(busy_o), 1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("t4_idle", 64'(busy_o), 0);
    chk("t4_pfdrop", 64'(pf_req_o), 0);
    chk("t4_nodone", 64'(done_o), 0);
    d1 = done_cnt;
    repeat (10) tick();
    @(negedge clk);
    chk("t4_late_pfreq", 64'(pf_req_o), 0);
    chk("t4_late_busy", 64'(busy_o), 0);
    chk("t4_late_done", 64'(done_cnt - d0), 0);
    chk("t4_ncache", 64'(cq.size()), 3);

    // Address wrap, and a trigger while busy
    idx_base_cur = 32'h400;
    idx_mem[0] = 8;
    lat = 0; pf_ack_i = 1'b0;
    cq.delete(); pq.delete(); d0 = done_cnt;
    pulse_trigger(32'h400, 32'hFFFF_FFF0, 16'd1, 3'd2);
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (pf_req_o) hit = 1'b1;
    end
    chk("t5_pfreq", 64'(hit), 1);
    chk("t5_wrap", 64'(pf_addr_o), 64'h10);
    pulse_trigger(32'h999, 32'h0, 16'd0, 3'd0);
    @(negedge clk);
    chk("t5_busytrig_nodone", 64'(done_o), 0);
    chk("t5_busytrig_addr", 64'(pf_addr_o), 64'h10);
    chk("t5_busytrig_busy", 64'(busy_o), 1);
    tick();
    pf_ack_i = 1'b1;
    wait_done("t5_done", 50);
    tick(); tick();
    chk("t5_npf", 64'(pq.size()), 1);
    chk("t5_paddr", 64'(pq.size() > 0 ? pq[0] : 32'hdead), 64'h10);
    chk("t5_caddr", 64'(cq.size() > 0 ? cq[0] : 32'hdead), 64'h400);
    chk("t5_ndone", 64'(done_cnt - d0), 1);
    chk("t5_cnt", 64'(pf_issued_cnt_o), PERF ? 64'd1 : 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
